// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, default frame header
// byte and instruction word width.
package boot_pkg;

    localparam int unsigned InstrWidth = 32;
    localparam logic [7:0]  HdrDefault = 8'hB7;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StData,
        StCsum,
        StRun,
        StErr
    } boot_state_e;

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: 4-byte big-endian shift register, byte-lane counter and
// running XOR of every data byte shifted in since the last clear.
module boot_word_asm
    import boot_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  shift_en,
    input  logic [7:0]            data,
    output logic                  word_done,
    output logic                  word_valid,
    output logic [InstrWidth-1:0] word,
    output logic [7:0]            csum
);

    logic [1:0]  lane;
    logic [23:0] shreg;

    // The byte being accepted completes a word when it lands in the last lane
    assign word_done = shift_en && (lane == 2'd3);

    // Shift bytes MSB first; publish the finished word for exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane       <= 2'd0;
            shreg      <= 24'd0;
            csum       <= 8'd0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane  <= 2'd0;
                shreg <= 24'd0;
                csum  <= 8'd0;
            end else if (shift_en) begin
                lane  <= lane + 2'd1;
                shreg <= {shreg[15:0], data};
                csum  <= csum ^ data;
                if (lane == 2'd3) begin
                    word_valid <= 1'b1;
                    word       <= {shreg, data};
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Framed program loader: HDR, LEN_HI, LEN_LO, 4*N data bytes, CSUM. Writes the
// assembled words to instruction memory at 0..N-1 and then pulses run_cpu.
// Optional feature macro: BOOT_CHECKSUM_EN (when undefined the frame carries no
// CSUM byte and the CPU is started right after the last word is written).
module boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned AW  = 10,
    parameter logic [7:0]  HDR = HdrDefault
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [AW-1:0]         imem_addr,
    output logic [InstrWidth-1:0] imem_wdata,
    output logic                  run_cpu,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Largest legal word count; N is 16 bits so 17 bits holds 2^AW for AW <= 16
    localparam logic [16:0] Capacity = 17'd1 << AW;

    boot_state_e state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [AW:0] word_count;

    logic        take;
    logic        is_hdr;
    logic [15:0] len_next;
    logic        len_oversize;
    logic        last_word;
    logic        asm_clear;
    logic        shift_en;
    logic        word_done;
    logic [7:0]  csum;

    assign take         = rx_valid && rx_ready;
    assign is_hdr       = (rx_data == HDR);
    assign len_next     = {len_hi, rx_data};
    assign len_oversize = ({1'b0, len_next} > Capacity);
    assign last_word    = ((17'(word_count) + 17'd1) == {1'b0, len});
    assign asm_clear    = take && is_hdr && ((state == StIdle) || (state == StErr));
    assign shift_en     = take && (state == StData);

`ifndef BOOT_CHECKSUM_EN
    logic unused_csum;
    assign unused_csum = ^csum;
`endif

    boot_word_asm u_word_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .shift_en  (shift_en),
        .data      (rx_data),
        .word_done (word_done),
        .word_valid(imem_we),
        .word      (imem_wdata),
        .csum      (csum)
    );

    // Frame FSM with registered status outputs and the write address counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            rx_ready   <= 1'b1;
            imem_addr  <= '0;
            run_cpu    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            len_hi     <= 8'd0;
            len        <= 16'd0;
            word_count <= '0;
        end else begin
            run_cpu  <= 1'b0;
            rx_ready <= 1'b1;
            case (state)
                StIdle, StErr: begin
                    if (take && is_hdr) begin
                        state      <= StLenHi;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                    end
                end
                StLenHi: begin
                    if (take) begin
                        len_hi <= rx_data;
                        state  <= StLenLo;
                    end
                end
                StLenLo: begin
                    if (take) begin
                        len <= len_next;
                        if (len_oversize) begin
                            state <= StErr;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (len_next == 16'd0) begin
`ifdef BOOT_CHECKSUM_EN
                            state <= StCsum;
`else
                            state    <= StRun;
                            run_cpu  <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
`endif
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (word_done) begin
                        imem_addr  <= word_count[AW-1:0];
                        word_count <= word_count + 1'b1;
                        if (last_word) begin
                            state <= StCsum;
                        end
                    end
                end
                StCsum: begin
`ifdef BOOT_CHECKSUM_EN
                    if (take) begin
                        if (rx_data == csum) begin
                            state    <= StRun;
                            run_cpu  <= 1'b1;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            rx_ready <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
`else
                    // One drain cycle so run_cpu follows the last imem write
                    state    <= StRun;
                    run_cpu  <= 1'b1;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    rx_ready <= 1'b0;
`endif
                end
                StRun: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
